// File: rtl/jelly2_wb_semaphore.sv
// Wishbone counting-semaphore block: SEM_NUM saturating counters bumped by bus
// SIGNAL writes or sig_i pulses and consumed by POLL reads, with one-cycle acks.
module jelly2_wb_semaphore #(
  parameter int unsigned WB_ADR_WIDTH = 37,
  parameter int unsigned WB_DAT_WIDTH = 64,
  parameter int unsigned WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
  parameter int unsigned SEM_NUM      = 4,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter logic [63:0] CORE_ID      = 64'h0000_0000_527a_0301
) (
  input  logic                    s_wb_clk_i,
  input  logic                    s_wb_rst_i,
  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic                    s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic                    s_wb_stb_i,
  output logic                    s_wb_ack_o,
  input  logic [SEM_NUM-1:0]      sig_i,
  output logic [SEM_NUM-1:0]      irq_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [8:0]           SEM_BASE = 9'h010;
  localparam logic [8:0]           SEM_END  = 9'(16 + 4 * SEM_NUM);

  logic                               ack_q, ack_d;
  logic [WB_DAT_WIDTH-1:0]            dat_q, dat_d;
  logic [SEM_NUM-1:0][CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [SEM_NUM-1:0]                 ovf_q, ovf_d;
  logic [SEM_NUM-1:0]                 irq_q, irq_d;

  logic                    acc;
  logic                    sem_hit;
  logic [7:0]              off;
  logic [7:0]              rel;
  logic [3:0]              sem_idx;
  logic [1:0]              fn;
  logic [CNT_WIDTH-1:0]    sel_cnt;
  logic                    sel_ovf;
  logic [WB_DAT_WIDTH-1:0] rdata;
  logic [CNT_WIDTH+1:0]    sum;
  logic                    hit, wr_cnt, inc_bus, do_poll, clr;
  logic                    unused_bits;

  // Byte-lane merge of bus data into a counter; lanes beyond CNT_WIDTH are ignored.
  function automatic logic [CNT_WIDTH-1:0] byte_merge(
    input logic [CNT_WIDTH-1:0]    old,
    input logic [WB_DAT_WIDTH-1:0] dat,
    input logic [WB_SEL_WIDTH-1:0] sel
  );
    logic [CNT_WIDTH-1:0] res;
    res = old;
    for (int j = 0; j < CNT_WIDTH; j++) begin
      res[j] = sel[j / 8] ? dat[j] : old[j];
    end
    return res;
  endfunction

  // Accept qualification and register-offset decode (only the low byte matters).
  always_comb begin
    acc     = s_wb_stb_i & ~ack_q;
    off     = s_wb_adr_i[7:0];
    rel     = off - 8'h10;
    sem_idx = rel[5:2];
    fn      = off[1:0];
    sem_hit = ({1'b0, off} >= SEM_BASE) && ({1'b0, off} < SEM_END);
  end

  // Per-semaphore next state: net increments/decrements, saturation and overflow.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    irq_d   = '0;
    sum     = '0;
    hit     = 1'b0;
    wr_cnt  = 1'b0;
    inc_bus = 1'b0;
    do_poll = 1'b0;
    clr     = 1'b0;
    for (int i = 0; i < SEM_NUM; i++) begin
      hit     = acc && sem_hit && (sem_idx == 4'(i));
      wr_cnt  = hit &&  s_wb_we_i && (fn == 2'd0);
      inc_bus = hit &&  s_wb_we_i && (fn == 2'd1);
      do_poll = hit && !s_wb_we_i && (fn == 2'd2) && (cnt_q[i] != '0);
      clr     = hit &&  s_wb_we_i && (fn == 2'd3) && s_wb_dat_i[0] && s_wb_sel_i[0];
      sum     = {2'b00, cnt_q[i]} + (CNT_WIDTH+2)'(inc_bus)
              + (CNT_WIDTH+2)'(sig_i[i]) - (CNT_WIDTH+2)'(do_poll);
      // A COUNT write wins outright: a coincident sig_i pulse is dropped silently.
      if (wr_cnt) begin
        cnt_d[i] = byte_merge(cnt_q[i], s_wb_dat_i, s_wb_sel_i);
        ovf_d[i] = ovf_q[i];
      end else if (sum > {2'b00, CNT_MAX}) begin
        cnt_d[i] = CNT_MAX;
        ovf_d[i] = 1'b1;
      end else begin
        cnt_d[i] = sum[CNT_WIDTH-1:0];
        ovf_d[i] = clr ? 1'b0 : ovf_q[i];
      end
      irq_d[i] = (cnt_d[i] != '0);
    end
  end

  // Read mux and bus response; write accesses return zero data.
  always_comb begin
    sel_cnt = '0;
    sel_ovf = 1'b0;
    for (int i = 0; i < SEM_NUM; i++) begin
      sel_cnt = (sem_idx == 4'(i)) ? cnt_q[i] : sel_cnt;
      sel_ovf = (sem_idx == 4'(i)) ? ovf_q[i] : sel_ovf;
    end
    if (off == 8'h00) begin
      rdata = WB_DAT_WIDTH'(CORE_ID);
    end else if (sem_hit) begin
      case (fn)
        2'd0:    rdata = WB_DAT_WIDTH'(sel_cnt);
        2'd2:    rdata = WB_DAT_WIDTH'(sel_cnt != '0);
        2'd3:    rdata = WB_DAT_WIDTH'(sel_ovf);
        default: rdata = '0;
      endcase
    end else begin
      rdata = '0;
    end
    ack_d = acc;
    dat_d = (acc && !s_wb_we_i) ? rdata : '0;
  end

  // State and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge s_wb_clk_i or posedge s_wb_rst_i) begin
    if (s_wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      cnt_q <= '0;
      ovf_q <= '0;
      irq_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      irq_q <= irq_d;
    end
  end

  assign s_wb_ack_o  = ack_q;
  assign s_wb_dat_o  = dat_q;
  assign irq_o       = irq_q;
  assign unused_bits = ^{s_wb_adr_i, s_wb_dat_i, s_wb_sel_i, rel};

endmodule

// File: tb/tb_jelly2_wb_semaphore.sv
// Self-checking bench for jelly2_wb_semaphore: directed register scenarios plus
// randomized bus/sig_i traffic compared every cycle against a behavioural model.
module tb_jelly2_wb_semaphore;

  localparam logic [63:0] ID_VAL = 64'h0000_0000_527a_0301;
  localparam int          MAXC   = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [36:0] adr = '0;
  logic [63:0] dat_i = '0;
  logic [63:0] dat_o;
  logic        we = 1'b0;
  logic [7:0]  sel = '0;
  logic        stb = 1'b0;
  logic        ack;
  logic [3:0]  sig = '0;
  logic [3:0]  irq;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  jelly2_wb_semaphore dut (
    .s_wb_clk_i(clk), .s_wb_rst_i(rst), .s_wb_adr_i(adr), .s_wb_dat_i(dat_i),
    .s_wb_dat_o(dat_o), .s_wb_we_i(we), .s_wb_sel_i(sel), .s_wb_stb_i(stb),
    .s_wb_ack_o(ack), .sig_i(sig), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counts as plain integers, updated once per clock.
  int          m_cnt [4];
  bit          m_ovf [4];
  bit          m_ack;
  logic [63:0] m_dat;

  always @(posedge clk or posedge rst) begin
    int add [4];
    int dec [4];
    bit clr [4];
    bit wrf [4];
    int wrv [4];
    int a, i, v;
    bit accept;
    logic [63:0] rd;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_cnt[k] = 0;
        m_ovf[k] = 1'b0;
      end
      m_ack = 1'b0;
      m_dat = '0;
    end else begin
      accept = stb && !m_ack;
      rd = '0;
      for (int k = 0; k < 4; k++) begin
        add[k] = int'(sig[k]);
        dec[k] = 0;
        clr[k] = 1'b0;
        wrf[k] = 1'b0;
        wrv[k] = 0;
      end
      if (accept) begin
        a = int'(adr[7:0]);
        if (a == 0) begin
          if (!we) rd = ID_VAL;
        end else if (a >= 16 && a < 32) begin
          i = (a - 16) / 4;
          case (a % 4)
            0: if (we) begin
                 wrf[i] = 1'b1;
                 wrv[i] = m_cnt[i];
                 if (sel[0]) wrv[i] = (wrv[i] & 'hff00) | int'(dat_i[7:0]);
                 if (sel[1]) wrv[i] = (wrv[i] & 'h00ff) | (int'(dat_i[15:8]) << 8);
               end else rd = 64'(m_cnt[i]);
            1: if (we) add[i] = add[i] + 1;
            2: if (!we) begin
                 rd = (m_cnt[i] > 0) ? 64'd1 : 64'd0;
                 if (m_cnt[i] > 0) dec[i] = 1;
               end
            default: if (we) clr[i] = dat_i[0] && sel[0];
                     else rd = 64'(m_ovf[i]);
          endcase
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (wrf[k]) m_cnt[k] = wrv[k];
        else begin
          v = m_cnt[k] + add[k] - dec[k];
          if (v > MAXC) begin
            v = MAXC;
            m_ovf[k] = 1'b1;
          end else if (clr[k]) m_ovf[k] = 1'b0;
          m_cnt[k] = v;
        end
      end
      m_ack = accept;
      m_dat = (accept && !we) ? rd : 64'd0;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [3:0] e_irq;
    if (cmp_en) begin
      for (int k = 0; k < 4; k++) e_irq[k] = (m_cnt[k] > 0);
      check("cyc_ack", 64'(ack), 64'(m_ack));
      check("cyc_dat", dat_o, m_dat);
      check("cyc_irq", 64'(irq), 64'(e_irq));
    end
  end

  task automatic access(input logic [7:0] off, input bit w, input logic [63:0] d,
                        input logic [7:0] s, output logic [63:0] rd);
    int n;
    n = 0;
    adr = 37'({$urandom(), $urandom()});
    adr[7:0] = off;
    we = w; dat_i = d; sel = s; stb = 1'b1;
    @(posedge clk); #1;
    while (!ack && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("ack_latency", 64'(n), 64'd0);
    rd = dat_o;
    stb = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [63:0] r;
  int          acks;
  int          pick;
  logic [7:0]  off;

  initial begin
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    access(8'h00, 1'b0, 64'd0, 8'hff, r); check("id", r, ID_VAL);
    access(8'h10, 1'b0, 64'd0, 8'hff, r); check("cnt0_reset", r, 64'd0);

    access(8'h10, 1'b1, 64'h0123456789abcdef, 8'h01, r);
    access(8'h10, 1'b0, 64'd0, 8'hff, r); check("cnt0_sel01", r, 64'h00ef);
    access(8'h10, 1'b1, 64'h0123456789abcdef, 8'h0f, r);
    access(8'h10, 1'b0, 64'd0, 8'hff, r); check("cnt0_sel0f", r, 64'hcdef);
    check("irq0_set", 64'(irq[0]), 64'd1);

    access(8'h14, 1'b1, 64'd2, 8'hff, r);
    access(8'h16, 1'b0, 64'd0, 8'hff, r); check("poll1_a", r, 64'd1);
    check("irq1_mid", 64'(irq[1]), 64'd1);
    access(8'h16, 1'b0, 64'd0, 8'hff, r); check("poll1_b", r, 64'd1);
    check("irq1_fall", 64'(irq[1]), 64'd0);
    access(8'h16, 1'b0, 64'd0, 8'hff, r); check("poll1_c", r, 64'd0);
    access(8'h14, 1'b0, 64'd0, 8'hff, r); check("cnt1_zero", r, 64'd0);

    access(8'h18, 1'b1, 64'hffff, 8'hff, r);
    access(8'h19, 1'b1, 64'd0, 8'h00, r);
    access(8'h18, 1'b0, 64'd0, 8'hff, r); check("cnt2_sat", r, 64'hffff);
    access(8'h1b, 1'b0, 64'd0, 8'hff, r); check("ovf2_set", r, 64'd1);
    access(8'h1b, 1'b1, 64'd1, 8'h01, r);
    access(8'h1b, 1'b0, 64'd0, 8'hff, r); check("ovf2_clr", r, 64'd0);

    access(8'h11, 1'b0, 64'd0, 8'hff, r); check("signal_rd", r, 64'd0);
    access(8'h80, 1'b0, 64'd0, 8'hff, r); check("unmapped_rd", r, 64'd0);
    access(8'h00, 1'b1, 64'hdead, 8'hff, r);
    access(8'h00, 1'b0, 64'd0, 8'hff, r); check("id_ro", r, ID_VAL);

    // POLL on an empty semaphore coinciding with a sig_i pulse.
    access(8'h10, 1'b1, 64'd0, 8'hff, r);
    adr = '0; adr[7:0] = 8'h12; we = 1'b0; sel = 8'hff; stb = 1'b1; sig = 4'b0001;
    @(posedge clk); #1;
    sig = 4'b0000; stb = 1'b0;
    check("pollsig_ack", 64'(ack), 64'd1);
    check("pollsig_dat", dat_o, 64'd0);
    @(posedge clk); #1;
    access(8'h10, 1'b0, 64'd0, 8'hff, r); check("pollsig_cnt", r, 64'd1);

    adr = '0; we = 1'b0; stb = 1'b1; acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    stb = 1'b0;
    check("held_stb_acks", 64'(acks), 64'd3);
    @(posedge clk); #1;

    // Reset arriving between accept and ack.
    access(8'h14, 1'b1, 64'd5, 8'hff, r);
    adr = '0; adr[7:0] = 8'h10; we = 1'b1; dat_i = 64'd7; sel = 8'hff; stb = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("inflight_ack", 64'(ack), 64'd0);
    check("inflight_irq", 64'(irq), 64'd0);
    stb = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    access(8'h10, 1'b0, 64'd0, 8'hff, r); check("post_rst_cnt0", r, 64'd0);
    access(8'h14, 1'b0, 64'd0, 8'hff, r); check("post_rst_cnt1", r, 64'd0);

    // Randomized traffic checked by the per-cycle compare process.
    for (int c = 0; c < 4000; c++) begin
      pick = $urandom_range(0, 9);
      if (pick < 8)       off = 8'h10 + 8'($urandom_range(0, 15));
      else if (pick == 8) off = 8'h00;
      else                off = 8'($urandom_range(0, 255));
      adr = 37'({$urandom(), $urandom()});
      adr[7:0] = off;
      stb = ($urandom_range(0, 3) != 0);
      we  = 1'($urandom_range(0, 1));
      sel = 8'($urandom());
      case ($urandom_range(0, 4))
        0:       dat_i = 64'hffff;
        1:       dat_i = 64'hfffe;
        2:       dat_i = 64'd1;
        3:       dat_i = 64'd0;
        default: dat_i = {$urandom(), $urandom()};
      endcase
      sig = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      @(posedge clk); #1;
    end
    stb = 1'b0; sig = 4'b0000;
    repeat (2) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jelly2_wb_semaphore.md
JELLY2_WB_SEMAPHORE -- requirements
Module: jelly2_wb_semaphore

Interface
REQ-001 SHALL have parameter WB_ADR_WIDTH, default 37, word address width.
REQ-002 SHALL have parameter WB_DAT_WIDTH, default 64, data width; WB_SEL_WIDTH = WB_DAT_WIDTH/8.
REQ-003 SHALL have parameter SEM_NUM, default 4, number of semaphores (legal 1..16).
REQ-004 SHALL have parameter CNT_WIDTH, default 16, counter width; MAX = 2**CNT_WIDTH-1.
REQ-005 SHALL have parameter CORE_ID, default 64'h0000_0000_527a_0301, ID register value.
REQ-006 SHALL have ports:
- s_wb_clk_i  in  1  sole clock, rising edge.
- s_wb_rst_i  in  1  asynchronous, active-high reset.
- s_wb_adr_i  in  WB_ADR_WIDTH  word address.
- s_wb_dat_i  in  WB_DAT_WIDTH  write data.
- s_wb_dat_o  out  WB_DAT_WIDTH  read data, valid while ack high.
- s_wb_we_i  in  1  1=write, 0=read.
- s_wb_sel_i  in  WB_SEL_WIDTH  byte enables.
- s_wb_stb_i  in  1  strobe.
- s_wb_ack_o  out  1  acknowledge.
- sig_i  in  SEM_NUM  hardware signal pulses, one increment per high cycle.
- irq_o  out  SEM_NUM  bit i high while count[i] > 0.

Function
REQ-007 SHALL decode only adr[7:0]; higher bits ignored (aliasing).
REQ-008 SHALL map: 0x00 ID (RO, CORE_ID); 0x10+4*i COUNT (RW), +1 SIGNAL (WO), +2 POLL (RO with side effect), +3 STATUS (R, W1C); i < SEM_NUM.
REQ-009 SHALL accept an access on a cycle with stb=1 and ack=0; ack is a registered one-cycle pulse on the following cycle; latency exactly 1 cycle.
REQ-010 SHALL apply all side effects exactly once per accepted access, at the accept edge; stb held high yields one access every two cycles.
REQ-011 SHALL register s_wb_dat_o with the accept; dat_o = 0 when ack low.
REQ-012 SHALL return 0 on reads of unmapped or SIGNAL addresses, ignore writes to unmapped, ID or POLL addresses, and still ack them.
REQ-013 COUNT write SHALL byte-merge dat_i[CNT_WIDTH-1:0] into count[i] under sel; upper bits ignored; read returns count zero-extended.
REQ-014 SIGNAL write (any data, any sel) SHALL increment count[i]; at MAX count holds and STATUS[0] (overflow) sets.
REQ-015 POLL read SHALL return 1 and decrement count[i] if count[i] > 0, else return 0 with no change.
REQ-016 STATUS read SHALL return {63'b0, ovf}; write with dat_i[0]=1 and sel[0]=1 SHALL clear ovf.
REQ-017 sig_i[i] high SHALL increment count[i] that cycle with the same saturation/overflow rule as REQ-014.
REQ-018 Simultaneous events on one semaphore, net per cycle: SIGNAL write + sig_i = +2 (saturating at MAX, ovf if any increment lost); POLL + sig_i with count>0 = net 0, returns 1; POLL + sig_i with count=0 returns 0, count becomes 1; COUNT write + sig_i = written value (sig_i lost, no ovf); STATUS clear + overflow in the same cycle leaves ovf set.
REQ-019 irq_o SHALL be derived from registered counts (no combinational path from bus inputs).

Reset
REQ-020 s_wb_rst_i high SHALL immediately clear all counts, ovf bits, s_wb_ack_o, s_wb_dat_o and irq_o, independent of clock.
REQ-021 An access in flight when reset asserts SHALL be dropped with no ack and no side effect; accepts resume on the first rising edge after reset deasserts.

Verification
REQ-022 Read 0x00 after reset -> one ack one cycle after stb, dat = 64'h0000_0000_527a_0301; read 0x10 -> 0.
REQ-023 Write 0x10 dat 64'h0123456789abcdef sel 8'h01 -> COUNT[0] reads 0x00ef; same with sel 8'h0f -> reads 0xcdef; irq_o[0]=1.
REQ-024 COUNT[1]=2, three POLL reads of 0x16 -> 1, 1, 0; COUNT[1]=0; irq_o[1] falls after second poll.
REQ-025 COUNT[2]=0xffff, SIGNAL write 0x19 -> count stays 0xffff, STATUS 0x1b reads 1; write 1 to 0x1b -> reads 0.
REQ-026 COUNT[0]=0, POLL 0x12 accepted in same cycle as sig_i[0]=1 -> returns 0, COUNT[0] then reads 1; stb held 6 cycles -> exactly 3 acks.
REQ-027 Reset asserted between accept and ack -> no ack, counts 0; next read after deassert acks normally.
